// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator. A host command
// accepted on the cmd_* port becomes one AXI write (AW+W, then B) or one
// AXI read (AR, then R), and the outcome is returned on the rsp_* port.
// Unaligned commands are answered locally with SLVERR and never reach the bus.
module axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 20
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_aresetn,
  // host command port
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // host response port
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  // AXI write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  // AXI write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  // AXI write response channel
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  // AXI read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  // AXI read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int StrbW = C_M_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } state_e;

  state_e                          state_q;
  logic                            cmdReady_q;
  logic                            awValid_q;
  logic                            wValid_q;
  logic                            bReady_q;
  logic                            arValid_q;
  logic                            rReady_q;
  logic                            rspValid_q;
  logic                            awDone_q;
  logic                            wDone_q;
  logic                            write_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [StrbW-1:0]                wstrb_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                      resp_q;

  logic                            cmdFire;
  logic                            awDone_d;
  logic                            wDone_d;

  // Handshake qualifiers: a channel counts as done if it finished earlier or
  // is completing on this edge, so AW and W may finish in either order.
  always_comb begin
    cmdFire  = cmd_valid && cmdReady_q;
    awDone_d = awDone_q || (awValid_q && m_axi_awready);
    wDone_d  = wDone_q  || (wValid_q  && m_axi_wready);
  end

  // Transaction sequencer; every bus and host output is a register set here.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q    <= IDLE;
      cmdReady_q <= 1'b1;
      awValid_q  <= 1'b0;
      wValid_q   <= 1'b0;
      bReady_q   <= 1'b0;
      arValid_q  <= 1'b0;
      rReady_q   <= 1'b0;
      rspValid_q <= 1'b0;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmdFire) begin
            cmdReady_q <= 1'b0;
            write_q    <= cmd_write;
            addr_q     <= cmd_addr;
            wdata_q    <= cmd_wdata;
            wstrb_q    <= cmd_wstrb;
            rdata_q    <= '0;
            resp_q     <= 2'b00;
            if (cmd_addr[1:0] != 2'b00) begin
              resp_q     <= RespSlvErr;
              rspValid_q <= 1'b1;
              state_q    <= RSP;
            end else if (cmd_write) begin
              awValid_q <= 1'b1;
              wValid_q  <= 1'b1;
              awDone_q  <= 1'b0;
              wDone_q   <= 1'b0;
              state_q   <= WR;
            end else begin
              arValid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        WR: begin
          if (awValid_q && m_axi_awready) begin
            awValid_q <= 1'b0;
            awDone_q  <= 1'b1;
          end
          if (wValid_q && m_axi_wready) begin
            wValid_q <= 1'b0;
            wDone_q  <= 1'b1;
          end
          if (awDone_d && wDone_d) begin
            bReady_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi_bvalid) begin
            resp_q     <= m_axi_bresp;
            rdata_q    <= '0;
            bReady_q   <= 1'b0;
            rspValid_q <= 1'b1;
            state_q    <= RSP;
          end
        end
        RD_AR: begin
          if (m_axi_arready) begin
            arValid_q <= 1'b0;
            rReady_q  <= 1'b1;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (m_axi_rvalid) begin
            rdata_q    <= m_axi_rdata;
            resp_q     <= m_axi_rresp;
            rReady_q   <= 1'b0;
            rspValid_q <= 1'b1;
            state_q    <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            cmdReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // One address register feeds both AW and AR since only one is ever active.
  assign cmd_ready     = cmdReady_q;
  assign rsp_valid     = rspValid_q;
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awValid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wValid_q;
  assign m_axi_bready  = bReady_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arValid_q;
  assign m_axi_rready  = rReady_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed bench for axi_lite_master with a small
// AXI4-Lite memory slave whose ready/response behaviour is adjustable.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  logic [19:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [19:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  int tests = 0;
  int failures = 0;

  // slave configuration, written only by the test sequence
  int          awDelay = 0;
  int          wDelay = 0;
  int          arDelay = 0;
  logic [1:0]  slaveBresp = 2'b00;
  logic [1:0]  slaveRresp = 2'b00;
  logic [19:0] expAwaddr = '0;
  logic [31:0] expWdata = '0;

  // handshake monitor state, written only by the posedge monitor
  logic        awHs = 1'b0, wHs = 1'b0, bHs = 1'b0, arHs = 1'b0, rHs = 1'b0;
  logic [19:0] awAddrHs = '0, arAddrHs = '0;
  logic [31:0] wDataHs = '0;
  logic [3:0]  wStrbHs = '0;
  int          awvCycles = 0, wvCycles = 0, arvCycles = 0, bHsCount = 0, stableErrs = 0;

  // slave internal state, written only by the negedge slave
  logic [31:0] mem [logic [19:0]];
  int          awWait = 0, wWait = 0, arWait = 0;
  logic        awGot = 1'b0, wGot = 1'b0;

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(20)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(aresetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .m_axi_awaddr (awaddr),
    .m_axi_awprot (awprot),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready),
    .m_axi_araddr (araddr),
    .m_axi_arprot (arprot),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Records which handshakes completed at each edge and counts valid cycles.
  always @(posedge clk) begin
    awHs <= awvalid && awready;
    wHs  <= wvalid && wready;
    bHs  <= bvalid && bready;
    arHs <= arvalid && arready;
    rHs  <= rvalid && rready;
    if (awvalid && awready) awAddrHs <= awaddr;
    if (wvalid && wready) begin
      wDataHs <= wdata;
      wStrbHs <= wstrb;
    end
    if (arvalid && arready) arAddrHs <= araddr;
    if (awvalid) awvCycles <= awvCycles + 1;
    if (wvalid) wvCycles <= wvCycles + 1;
    if (arvalid) arvCycles <= arvCycles + 1;
    if (bvalid && bready) bHsCount <= bHsCount + 1;
    if ((awvalid && awaddr !== expAwaddr) || (wvalid && wdata !== expWdata))
      stableErrs <= stableErrs + 1;
  end

  // Memory slave: readies after a programmable wait, one B/R per request.
  always @(negedge clk) begin
    if (!aresetn) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      awWait = 0; wWait = 0; arWait = 0; awGot = 1'b0; wGot = 1'b0;
    end else begin
      if (awHs) begin
        awGot = 1'b1; awready = 1'b0; awWait = 0;
      end else if (awvalid && !awGot) begin
        awWait = awWait + 1;
        awready = (awWait > awDelay);
      end else begin
        awready = 1'b0;
      end
      if (wHs) begin
        wGot = 1'b1; wready = 1'b0; wWait = 0;
      end else if (wvalid && !wGot) begin
        wWait = wWait + 1;
        wready = (wWait > wDelay);
      end else begin
        wready = 1'b0;
      end
      if (bHs) bvalid = 1'b0;
      if (awGot && wGot && !bvalid) begin
        logic [31:0] cur;
        cur = memRead(awAddrHs);
        for (int b = 0; b < 4; b++)
          if (wStrbHs[b]) cur[8*b +: 8] = wDataHs[8*b +: 8];
        mem[awAddrHs] = cur;
        bvalid = 1'b1;
        bresp = slaveBresp;
        awGot = 1'b0;
        wGot = 1'b0;
      end
      if (rHs) rvalid = 1'b0;
      if (arHs) begin
        arready = 1'b0; arWait = 0;
        rvalid = 1'b1;
        rdata = memRead(arAddrHs);
        rresp = slaveRresp;
      end else if (arvalid) begin
        arWait = arWait + 1;
        arready = (arWait > arDelay);
      end else begin
        arready = 1'b0;
      end
    end
  end

  // Presents a command and waits for acceptance; returns just after the
  // accepting edge, i.e. at the start of cycle N+1.
  task automatic issueCmd(input logic w, input logic [19:0] a, input logic [31:0] d,
                          input logic [3:0] s, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  // Waits for a response, captures it and consumes it with rsp_ready.
  task automatic waitRsp(output bit ok, output logic w, output logic [31:0] d, output logic [1:0] r);
    ok = 1'b0; w = 1'bx; d = 'x; r = 'x;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1; w = rsp_write; d = rsp_rdata; r = rsp_resp;
        break;
      end
    end
    if (ok) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 7'b1000000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 1000000",
               {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid});
    end
    tests++;
    if ({awaddr, araddr, wdata, wstrb} !== 76'd0) begin
      failures++;
      $display("[TB] FAIL reset_bus: got awaddr=%h araddr=%h wdata=%h wstrb=%h, expected all 0",
               awaddr, araddr, wdata, wstrb);
    end
    tests++;
    if ({rsp_write, rsp_rdata, rsp_resp, awprot, arprot} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL reset_rsp: got write=%b rdata=%h resp=%b awprot=%b arprot=%b, expected all 0",
               rsp_write, rsp_rdata, rsp_resp, awprot, arprot);
    end
    #2 aresetn = 1'b1;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: got cmd_ready=%b rsp_valid=%b, expected 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_write_read;
    bit ok, okR; logic w; logic [31:0] d; logic [1:0] r;
    expAwaddr = 20'h00004; expWdata = 32'hDEADAFFE;
    issueCmd(1'b1, 20'h00004, 32'hDEADAFFE, 4'hF, ok);
    waitRsp(okR, w, d, r);
    tests++;
    if (!ok || !okR || w !== 1'b1 || r !== 2'b00 || d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL write_rsp: got ok=%b/%b write=%b resp=%b rdata=%h, expected 1/1 1 00 00000000",
               ok, okR, w, r, d);
    end
    issueCmd(1'b0, 20'h00004, 32'h0, 4'h0, ok);
    waitRsp(okR, w, d, r);
    tests++;
    if (!ok || !okR || w !== 1'b0 || r !== 2'b00 || d !== 32'hDEADAFFE) begin
      failures++;
      $display("[TB] FAIL read_back: got ok=%b/%b write=%b resp=%b rdata=%h, expected 1/1 0 00 deadaffe",
               ok, okR, w, r, d);
    end
  endtask

  task automatic test_weight_latency;
    bit ok;
    expAwaddr = 20'h8FFFC; expWdata = 32'hFEEDC0FE;
    issueCmd(1'b1, 20'h8FFFC, 32'hFEEDC0FE, 4'hF, ok);
    @(negedge clk);
    tests++;
    if (!ok || {awvalid, wvalid, rsp_valid, awaddr, wdata} !== {3'b110, 20'h8FFFC, 32'hFEEDC0FE}) begin
      failures++;
      $display("[TB] FAIL wr_n1: got ok=%b aw/w/rsp=%b%b%b awaddr=%h wdata=%h, expected 1 110 8fffc feedc0fe",
               ok, awvalid, wvalid, rsp_valid, awaddr, wdata);
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, bready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL wr_n2: got rsp_valid=%b bready=%b, expected 0 1", rsp_valid, bready);
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_write, rsp_resp, bready} !== 5'b11000) begin
      failures++;
      $display("[TB] FAIL wr_n3: got rsp_valid=%b write=%b resp=%b bready=%b, expected 1 1 00 0",
               rsp_valid, rsp_write, rsp_resp, bready);
    end
    rsp_ready = 1'b1; @(posedge clk); #1 rsp_ready = 1'b0;
    issueCmd(1'b0, 20'h8FFFC, 32'h0, 4'h0, ok);
    @(negedge clk);
    tests++;
    if (!ok || {arvalid, rsp_valid, araddr} !== {2'b10, 20'h8FFFC}) begin
      failures++;
      $display("[TB] FAIL rd_n1: got ok=%b arvalid=%b rsp_valid=%b araddr=%h, expected 1 1 0 8fffc",
               ok, arvalid, rsp_valid, araddr);
    end
    @(negedge clk);
    tests++;
    if ({rsp_valid, rready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rd_n2: got rsp_valid=%b rready=%b, expected 0 1", rsp_valid, rready);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFEEDC0FE || rsp_resp !== 2'b00 || rsp_write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rd_n3: got rsp_valid=%b rdata=%h resp=%b write=%b, expected 1 feedc0fe 00 0",
               rsp_valid, rsp_rdata, rsp_resp, rsp_write);
    end
    rsp_ready = 1'b1; @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_unaligned;
    bit ok; int ar0, aw0, w0;
    ar0 = arvCycles;
    issueCmd(1'b0, 20'h00006, 32'h0, 4'h0, ok);
    @(negedge clk);
    tests++;
    if (!ok || {rsp_valid, rsp_resp, rsp_rdata, arvalid} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL unaligned_rd: got ok=%b rsp_valid=%b resp=%b rdata=%h arvalid=%b, expected 1 1 10 00000000 0",
               ok, rsp_valid, rsp_resp, rsp_rdata, arvalid);
    end
    rsp_ready = 1'b1; @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (arvCycles - ar0 !== 0) begin
      failures++;
      $display("[TB] FAIL unaligned_no_ar: got %0d arvalid cycles, expected 0", arvCycles - ar0);
    end
    aw0 = awvCycles; w0 = wvCycles;
    issueCmd(1'b1, 20'h00005, 32'h55555555, 4'hF, ok);
    @(negedge clk);
    tests++;
    if (!ok || {rsp_valid, rsp_write, rsp_resp, awvalid, wvalid} !== 6'b111000) begin
      failures++;
      $display("[TB] FAIL unaligned_wr: got ok=%b rsp_valid=%b write=%b resp=%b aw=%b w=%b, expected 1 1 1 10 0 0",
               ok, rsp_valid, rsp_write, rsp_resp, awvalid, wvalid);
    end
    rsp_ready = 1'b1; @(posedge clk); #1 rsp_ready = 1'b0;
    tests++;
    if (awvCycles - aw0 !== 0 || wvCycles - w0 !== 0) begin
      failures++;
      $display("[TB] FAIL unaligned_no_aw: got aw=%0d w=%0d valid cycles, expected 0 0",
               awvCycles - aw0, wvCycles - w0);
    end
  endtask

  task automatic test_aw_w_skew;
    bit ok, okR; logic w; logic [31:0] d; logic [1:0] r; int a0, w0, b0, s0;
    awDelay = 4; wDelay = 0;
    expAwaddr = 20'h00010; expWdata = 32'hA5A55A5A;
    a0 = awvCycles; w0 = wvCycles; b0 = bHsCount; s0 = stableErrs;
    issueCmd(1'b1, 20'h00010, 32'hA5A55A5A, 4'hF, ok);
    waitRsp(okR, w, d, r);
    tests++;
    if (!ok || !okR || awvCycles - a0 !== 5 || wvCycles - w0 !== 1 || bHsCount - b0 !== 1 || r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL skew_aw_late: got ok=%b/%b aw=%0d w=%0d b=%0d resp=%b, expected 1/1 5 1 1 00",
               ok, okR, awvCycles - a0, wvCycles - w0, bHsCount - b0, r);
    end
    tests++;
    if (stableErrs - s0 !== 0) begin
      failures++;
      $display("[TB] FAIL skew_stable: got %0d unstable cycles, expected 0", stableErrs - s0);
    end
    awDelay = 0; wDelay = 3;
    expAwaddr = 20'h00014; expWdata = 32'h0BADF00D;
    a0 = awvCycles; w0 = wvCycles; b0 = bHsCount;
    issueCmd(1'b1, 20'h00014, 32'h0BADF00D, 4'hF, ok);
    waitRsp(okR, w, d, r);
    tests++;
    if (!ok || !okR || awvCycles - a0 !== 1 || wvCycles - w0 !== 4 || bHsCount - b0 !== 1) begin
      failures++;
      $display("[TB] FAIL skew_w_late: got ok=%b/%b aw=%0d w=%0d b=%0d, expected 1/1 1 4 1",
               ok, okR, awvCycles - a0, wvCycles - w0, bHsCount - b0);
    end
    wDelay = 0;
    expAwaddr = 20'h00010; expWdata = 32'hFFFFFFFF;
    issueCmd(1'b1, 20'h00010, 32'hFFFFFFFF, 4'b0101, ok);
    waitRsp(okR, w, d, r);
    issueCmd(1'b0, 20'h00010, 32'h0, 4'h0, ok);
    waitRsp(okR, w, d, r);
    tests++;
    if (!ok || !okR || d !== 32'hA5FF5AFF) begin
      failures++;
      $display("[TB] FAIL wstrb_merge: got ok=%b/%b rdata=%h, expected 1/1 a5ff5aff", ok, okR, d);
    end
  endtask

  task automatic test_backpressure_error;
    bit ok, okR, seen, stable; logic w; logic [31:0] d; logic [1:0] r;
    slaveRresp = 2'b11;
    issueCmd(1'b0, 20'h00004, 32'h0, 4'h0, ok);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    slaveRresp = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h8FFFC;
    stable = seen;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready, arvalid} !== {4'b1011, 32'hDEADAFFE, 2'b00})
        stable = 1'b0;
    end
    tests++;
    if (!ok || !stable) begin
      failures++;
      $display("[TB] FAIL rsp_hold: got ok=%b stable=%b rsp_valid=%b resp=%b rdata=%h cmd_ready=%b, expected 1 1 1 11 deadaffe 0",
               ok, stable, rsp_valid, rsp_resp, rsp_rdata, cmd_ready);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if ({cmd_ready, rsp_valid, arvalid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL second_cmd_wait: got cmd_ready=%b rsp_valid=%b arvalid=%b, expected 1 0 0",
               cmd_ready, rsp_valid, arvalid);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    tests++;
    if ({arvalid, cmd_ready, araddr} !== {2'b10, 20'h8FFFC}) begin
      failures++;
      $display("[TB] FAIL second_cmd_accept: got arvalid=%b cmd_ready=%b araddr=%h, expected 1 0 8fffc",
               arvalid, cmd_ready, araddr);
    end
    waitRsp(okR, w, d, r);
    tests++;
    if (!okR || d !== 32'hFEEDC0FE || r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL second_cmd_data: got ok=%b rdata=%h resp=%b, expected 1 feedc0fe 00", okR, d, r);
    end
    slaveBresp = 2'b10;
    expAwaddr = 20'h00008; expWdata = 32'h11111111;
    issueCmd(1'b1, 20'h00008, 32'h11111111, 4'hF, ok);
    waitRsp(okR, w, d, r);
    slaveBresp = 2'b00;
    tests++;
    if (!ok || !okR || w !== 1'b1 || r !== 2'b10 || d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL bresp_pass: got ok=%b/%b write=%b resp=%b rdata=%h, expected 1/1 1 10 00000000",
               ok, okR, w, r, d);
    end
  endtask

  task automatic test_reset_mid;
    bit ok, okR, rspSeen, busy; logic w; logic [31:0] d; logic [1:0] r;
    arDelay = 20;
    issueCmd(1'b0, 20'h00004, 32'h0, 4'h0, ok);
    @(negedge clk);
    #2;
    busy = arvalid;
    aresetn = 1'b0;
    #1;
    tests++;
    if (!ok || !busy || {arvalid, rready, rsp_valid, cmd_ready} !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL reset_async: got ok=%b busy=%b arvalid=%b rready=%b rsp_valid=%b cmd_ready=%b, expected 1 1 0 0 0 1",
               ok, busy, arvalid, rready, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    #2 aresetn = 1'b1;
    arDelay = 0;
    rspSeen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || arvalid) rspSeen = 1'b1;
    end
    tests++;
    if (rspSeen || cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_quiet: got activity=%b cmd_ready=%b, expected 0 1", rspSeen, cmd_ready);
    end
    issueCmd(1'b0, 20'h8FFFC, 32'h0, 4'h0, ok);
    waitRsp(okR, w, d, r);
    tests++;
    if (!ok || !okR || d !== 32'hFEEDC0FE || r !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_recover: got ok=%b/%b rdata=%h resp=%b, expected 1/1 feedc0fe 00", ok, okR, d, r);
    end
  endtask

  // Backstop against a hung sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected sequence to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_write_read();
    test_weight_latency();
    test_unaligned();
    test_aw_w_skew();
    test_backpressure_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
